game_engine_gen2: RTL and testbench

- Parametrised successor of the LED-strip game controller.
- Sits between the sequence generator (supplies `grb_in` and `flag`) and the LED driver (consumes `grb_seq` and `refresh`).
- Adds the following over the previous generation:
  - configurable LED count, flash timing and win level
  - a lives counter with a game-over state
  - a frozen flash frame and a distinct miss colour
  - an animated win pattern
  - edge-detected go, with restart from the terminal states

---
 rtl/game_pkg.sv | 30 +++
 rtl/game_flash_timer.sv | 44 ++++
 rtl/game_engine_gen2.sv | 180 ++++++++++++++++++
 tb/tb_game_engine_gen2.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared types, colour constants and frame helper for the game engine
package game_pkg;

  typedef enum logic [2:0] {
    PLAY     = 3'd0,
    FLASH    = 3'd1,
    RESOLVE  = 3'd2,
    WIN      = 3'd3,
    GAMEOVER = 3'd4
  } state_t;

  localparam logic [23:0] GRB_OFF        = 24'h000000;
  localparam logic [23:0] MISS_COLOR_DEF = 24'h00FF00;
  localparam logic [23:0] WIN_COLOR_DEF  = 24'hFF0000;

  // Widest strip the replication helper can build; callers cast down to their frame width.
  localparam int MAX_LEDS = 64;
  localparam int MAX_FW   = 24 * MAX_LEDS;

  // Fill the first num_leds LED slots with one colour; LED i sits at bits [24*i +: 24].
  function automatic logic [MAX_FW-1:0] grb_replicate(input logic [23:0] color, input int num_leds);
    logic [MAX_FW-1:0] f;
    f = '0;
    for (int i = 0; i < MAX_LEDS; i++) begin
      if (i < num_leds) f[24*i +: 24] = color;
    end
    return f;
  endfunction

endpackage

// File: rtl/game_flash_timer.sv
// rtl/game_flash_timer.sv - half-period counter with on/off phase and pair count
module game_flash_timer #(
  parameter int HALF  = 2**24,
  parameter int COUNT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic enable,
  output logic tick,
  output logic phase,
  output logic done
);

  localparam int TW = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int PW = $clog2(COUNT + 1);

  logic [TW-1:0] tcnt;
  logic [PW-1:0] pairs;

  // tick marks the last cycle of a half-period; done is the tick closing the final OFF half
  assign tick  = enable & (tcnt == TW'(HALF - 1));
  assign done  = tick & ~phase & (pairs == PW'(COUNT - 1));

  // start restarts in the ON phase; pairs counts completed ON/OFF pairs (OFF->ON toggles)
  always_ff @(posedge clk) begin
    if (reset) begin
      tcnt  <= '0;
      phase <= 1'b0;
      pairs <= '0;
    end else if (start) begin
      tcnt  <= '0;
      phase <= 1'b1;
      pairs <= '0;
    end else if (tick) begin
      tcnt  <= '0;
      phase <= ~phase;
      if (!phase) pairs <= pairs + PW'(1);
    end else if (enable) begin
      tcnt <= tcnt + TW'(1);
    end
  end

endmodule

// File: rtl/game_engine_gen2.sv
// rtl/game_engine_gen2.sv - LED-strip game controller: play, flash, lives, win chaser, game over
module game_engine_gen2
  import game_pkg::*;
#(
  parameter int          NUM_LEDS    = 5,
  parameter int          WIN_LVL     = 5,
  parameter int          LIVES       = 3,
  parameter int          FLASH_HALF  = 2**24,
  parameter int          FLASH_COUNT = 4,
  parameter logic [23:0] MISS_COLOR  = MISS_COLOR_DEF,
  parameter logic [23:0] WIN_COLOR   = WIN_COLOR_DEF,
  localparam int         FW          = 24 * NUM_LEDS,
  localparam int         LW          = $clog2(WIN_LVL + 1),
  localparam int         VW          = $clog2(LIVES + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          go,
  input  logic          cycle,
  input  logic          flag,
  input  logic [FW-1:0] grb_in,
  output logic [FW-1:0] grb_seq,
  output logic          refresh,
  output logic          run,
  output logic [LW-1:0] lvl,
  output logic [VW-1:0] lives_left,
  output logic          win,
  output logic          lose
);

  localparam int IW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

  state_t        state, state_d;
  logic          go_q, go_rise;
  logic          hit_r, hit_d;
  logic [FW-1:0] snap, snap_d;
  logic [FW-1:0] grb_d;
  logic [LW-1:0] lvl_d;
  logic [VW-1:0] lives_d;
  logic [IW-1:0] led_idx, led_d, step_idx;
  logic          upd;
  logic          t_start, t_enable, t_tick, t_phase, t_done;
  logic [FW-1:0] miss_frame, win_frame;

  assign go_rise    = go & ~go_q;
  assign miss_frame = FW'(grb_replicate(MISS_COLOR, NUM_LEDS));

  assign run  = (state == PLAY);
  assign win  = (state == WIN);
  assign lose = (state == GAMEOVER);

  assign t_enable = (state == FLASH) || (state == WIN);

  game_flash_timer #(
    .HALF  (FLASH_HALF),
    .COUNT (FLASH_COUNT)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .start  (t_start),
    .enable (t_enable),
    .tick   (t_tick),
    .phase  (t_phase),
    .done   (t_done)
  );

  // Chaser frame for the LED about to be lit: the next slot while in WIN, LED0 on WIN entry
  always_comb begin
    step_idx = '0;
    if (state == WIN) begin
      step_idx = (led_idx == IW'(NUM_LEDS - 1)) ? '0 : led_idx + IW'(1);
    end
    win_frame = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      win_frame[24*i +: 24] = (IW'(i) == step_idx) ? WIN_COLOR : GRB_OFF;
    end
  end

  // Next-state and datapath decisions; upd flags every internally generated frame change
  always_comb begin
    state_d = state;
    grb_d   = grb_seq;
    lvl_d   = lvl;
    lives_d = lives_left;
    led_d   = led_idx;
    snap_d  = snap;
    hit_d   = hit_r;
    upd     = 1'b0;
    t_start = 1'b0;
    case (state)
      PLAY: begin
        grb_d = grb_in;
        if (go_rise) begin
          snap_d  = grb_in;
          hit_d   = flag;
          t_start = 1'b1;
          grb_d   = flag ? grb_in : miss_frame;
          upd     = 1'b1;
          state_d = FLASH;
        end
      end
      FLASH: begin
        // the closing tick leaves the OFF frame in place for RESOLVE
        if (t_done) begin
          state_d = RESOLVE;
        end else if (t_tick) begin
          grb_d = t_phase ? {FW{1'b0}} : (hit_r ? snap : miss_frame);
          upd   = 1'b1;
        end
      end
      RESOLVE: begin
        if (hit_r) begin
          lvl_d = (lvl == LW'(WIN_LVL)) ? lvl : lvl + LW'(1);
          if (lvl + LW'(1) == LW'(WIN_LVL)) begin
            led_d   = '0;
            t_start = 1'b1;
            grb_d   = win_frame;
            upd     = 1'b1;
            state_d = WIN;
          end else begin
            state_d = PLAY;
          end
        end else if (lives_left <= VW'(1)) begin
          lives_d = '0;
          grb_d   = miss_frame;
          upd     = 1'b1;
          state_d = GAMEOVER;
        end else begin
          lives_d = lives_left - VW'(1);
          state_d = PLAY;
        end
      end
      WIN: begin
        if (go_rise) begin
          lvl_d   = '0;
          lives_d = VW'(LIVES);
          state_d = PLAY;
        end else if (t_tick) begin
          led_d = step_idx;
          grb_d = win_frame;
          upd   = 1'b1;
        end
      end
      GAMEOVER: begin
        if (go_rise) begin
          lvl_d   = '0;
          lives_d = VW'(LIVES);
          state_d = PLAY;
        end
      end
      default: state_d = PLAY;
    endcase
  end

  // State and datapath registers; refresh lands in the same cycle as the new frame
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= PLAY;
      grb_seq    <= '0;
      refresh    <= 1'b0;
      lvl        <= '0;
      lives_left <= VW'(LIVES);
      led_idx    <= '0;
      snap       <= '0;
      hit_r      <= 1'b0;
      go_q       <= 1'b0;
    end else begin
      state      <= state_d;
      grb_seq    <= grb_d;
      refresh    <= cycle | upd;
      lvl        <= lvl_d;
      lives_left <= lives_d;
      led_idx    <= led_d;
      snap       <= snap_d;
      hit_r      <= hit_d;
      go_q       <= go;
    end
  end

endmodule

// File: tb/tb_game_engine_gen2.sv
// tb/tb_game_engine_gen2.sv - scoreboard bench for game_engine_gen2
module tb_game_engine_gen2;

  localparam int WIN_LVL = 2;

  logic         clk;
  logic         reset;
  logic         go;
  logic         cycle;
  logic         flag;
  logic [119:0] grb_in;
  logic [119:0] grb_seq;
  logic         refresh;
  logic         run;
  logic [1:0]   lvl;
  logic [1:0]   lives_left;
  logic         win;
  logic         lose;

  game_engine_gen2 #(
    .NUM_LEDS    (5),
    .WIN_LVL     (WIN_LVL),
    .LIVES       (2),
    .FLASH_HALF  (4),
    .FLASH_COUNT (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .go         (go),
    .cycle      (cycle),
    .flag       (flag),
    .grb_in     (grb_in),
    .grb_seq    (grb_seq),
    .refresh    (refresh),
    .run        (run),
    .lvl        (lvl),
    .lives_left (lives_left),
    .win        (win),
    .lose       (lose)
  );

  typedef struct {
    int           cyc;
    string        nm;
    logic [119:0] grb;
    logic [1:0]   lvl;
    logic [1:0]   lives;
    logic         run;
    logic         win;
    logic         lose;
  } snap_t;

  typedef struct {
    int           cyc;
    logic [119:0] grb;
  } ref_t;

  snap_t sq[$];
  ref_t  rq[$];
  int    cyc   = 0;
  int    tests = 0;
  int    fails = 0;

  logic [119:0] fa, fb, fc, fd, fe, miss_f;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [119:0] winf(input int i);
    logic [119:0] f;
    f = '0;
    f[24*i +: 24] = 24'hFF0000;
    return f;
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic exp_at(input int k, input string nm, input logic [119:0] g, input int lv, input int li,
                        input logic r, input logic w, input logic l);
    snap_t s;
    s.cyc = cyc + k; s.nm = nm; s.grb = g; s.lvl = 2'(lv); s.lives = 2'(li);
    s.run = r; s.win = w; s.lose = l;
    sq.push_back(s);
  endtask

  task automatic exp_ref(input int k, input logic [119:0] g);
    ref_t r;
    r.cyc = cyc + k; r.grb = g;
    rq.push_back(r);
  endtask

  // One go press in PLAY with hand-derived timing: flash frames at +1/+5/+9/+13, RESOLVE at +17.
  task automatic round(input bit hit, input logic [119:0] a, input logic [119:0] b,
                       input int lv, input int li, input bit hold);
    logic [119:0] on_f;
    bit           back_to_play;
    on_f = hit ? a : miss_f;
    back_to_play = 1'b0;
    flag = hit; go = 1'b1; grb_in = a;
    exp_ref(1, on_f); exp_ref(5, '0); exp_ref(9, on_f); exp_ref(13, '0);
    exp_at(1,  "flash_on0",  on_f, lv, li, 1'b0, 1'b0, 1'b0);
    exp_at(5,  "flash_off0", '0,   lv, li, 1'b0, 1'b0, 1'b0);
    exp_at(9,  "flash_on1",  on_f, lv, li, 1'b0, 1'b0, 1'b0);
    exp_at(17, "resolve",    '0,   lv, li, 1'b0, 1'b0, 1'b0);
    if (hit && lv + 1 == WIN_LVL) begin
      exp_ref(18, winf(0));
      exp_at(18, "win_entry", winf(0), lv + 1, li, 1'b0, 1'b1, 1'b0);
    end else if (!hit && li == 1) begin
      exp_ref(18, miss_f);
      exp_at(18, "gameover_entry", miss_f, lv, 0, 1'b0, 1'b0, 1'b1);
    end else begin
      back_to_play = 1'b1;
      exp_at(18, "play_return", '0, hit ? lv + 1 : lv, hit ? li : li - 1, 1'b1, 1'b0, 1'b0);
      exp_at(19, "play_live",   b,  hit ? lv + 1 : lv, hit ? li : li - 1, 1'b1, 1'b0, 1'b0);
    end
    step(1);
    if (!hold) go = 1'b0;
    flag = ~hit;
    grb_in = b;
    step(17);
    if (back_to_play) step(1);
  endtask

  // Monitor: frame snapshots due this cycle, and every refresh strobe against the refresh queue
  always @(negedge clk) begin
    snap_t s;
    ref_t  r;
    while (rq.size() > 0 && rq[0].cyc < cyc) begin
      r = rq.pop_front();
      tests++; fails++;
      $display("FAIL refresh_missing @%0d: no refresh seen, required one with grb=%h", r.cyc, r.grb);
    end
    if (refresh === 1'b1) begin
      if (rq.size() > 0 && rq[0].cyc == cyc) begin
        r = rq.pop_front();
        tests++;
        if (grb_seq !== r.grb) begin
          fails++;
          $display("FAIL refresh_frame @%0d: got grb=%h, want grb=%h", cyc, grb_seq, r.grb);
        end
      end else begin
        tests++; fails++;
        $display("FAIL refresh_unexpected @%0d: got refresh=1 grb=%h, want refresh=0", cyc, grb_seq);
      end
    end
    while (sq.size() > 0 && sq[0].cyc <= cyc) begin
      s = sq.pop_front();
      tests++;
      if (s.cyc != cyc) begin
        fails++;
        $display("FAIL %s: checked at cycle %0d, required at %0d", s.nm, cyc, s.cyc);
      end else if (grb_seq !== s.grb || lvl !== s.lvl || lives_left !== s.lives ||
                   run !== s.run || win !== s.win || lose !== s.lose) begin
        fails++;
        $display("FAIL %s @%0d: got grb=%h lvl=%0d lives=%0d run=%b win=%b lose=%b, want grb=%h lvl=%0d lives=%0d run=%b win=%b lose=%b",
                 s.nm, cyc, grb_seq, lvl, lives_left, run, win, lose,
                 s.grb, s.lvl, s.lives, s.run, s.win, s.lose);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1);
  end

  initial begin
    fa = 120'h0102030405060708090A0B0C0D0E0F;
    fb = 120'hA1A2A3A4A5A6A7A8A9AAABACADAEAF;
    fc = 120'h111111222222333333444444555555;
    fd = 120'hDEADBEEFCAFEF00D123456789ABCDE;
    fe = 120'h0F0E0D0C0B0A09080706050403020C;
    miss_f = {5{24'h00FF00}};

    // 1: reset holds outputs at reset values even with a live frame; then 1-cycle pass-through
    reset = 1'b1; go = 1'b0; cycle = 1'b0; flag = 1'b0; grb_in = fa;
    exp_at(2, "reset_state", '0, 0, 2, 1'b1, 1'b0, 1'b0);
    step(2);
    reset = 1'b0;
    exp_at(1, "play_passthru", fa, 0, 2, 1'b1, 1'b0, 1'b0);
    step(1);
    grb_in = fb; cycle = 1'b1;
    exp_ref(1, fb);
    exp_at(1, "cycle_refresh", fb, 0, 2, 1'b1, 1'b0, 1'b0);
    step(1);
    cycle = 1'b0;
    step(1);

    // 2: hit -> lvl 1
    round(1'b1, fa, fb, 0, 2, 1'b0);

    // 3: two misses -> lives 1 then GAMEOVER, go left held high
    round(1'b0, fb, fc, 1, 2, 1'b0);
    round(1'b0, fc, fd, 1, 1, 1'b1);

    // 4: held go does nothing; release and press restarts
    exp_at(4, "gameover_hold", miss_f, 1, 0, 1'b0, 1'b0, 1'b1);
    step(5);
    go = 1'b0;
    step(1);
    go = 1'b1; grb_in = fc;
    exp_at(1, "restart",      miss_f, 0, 2, 1'b1, 1'b0, 1'b0);
    exp_at(2, "restart_live", fc,     0, 2, 1'b1, 1'b0, 1'b0);
    step(1);
    go = 1'b0;
    step(1);

    // 5: two hits -> WIN, chaser steps every 4 cycles and wraps, go exits
    round(1'b1, fc, fd, 0, 2, 1'b0);
    round(1'b1, fd, fe, 1, 2, 1'b0);
    exp_at(2, "win_hold", winf(0), 2, 2, 1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      exp_ref(4 * k, winf(k % 5));
      exp_at(4 * k, "win_step", winf(k % 5), 2, 2, 1'b0, 1'b1, 1'b0);
    end
    step(22);
    go = 1'b1; grb_in = fa;
    exp_at(1, "win_exit",       winf(0), 0, 2, 1'b1, 1'b0, 1'b0);
    exp_at(2, "play_after_win", fa,      0, 2, 1'b1, 1'b0, 1'b0);
    step(1);
    go = 1'b0;
    step(1);

    // raise lvl so the mid-flash reset has something to clear
    round(1'b1, fb, fc, 0, 2, 1'b0);

    // 6: go pulses inside FLASH are ignored; reset in the 6th FLASH cycle
    go = 1'b1; flag = 1'b0; grb_in = fd;
    exp_ref(1, miss_f); exp_ref(5, '0);
    exp_at(1, "t6_flash_on", miss_f, 1, 2, 1'b0, 1'b0, 1'b0);
    step(1);
    go = 1'b0;
    step(1);
    go = 1'b1;
    step(1);
    go = 1'b0;
    exp_at(1, "t6_go_ignored", miss_f, 1, 2, 1'b0, 1'b0, 1'b0);
    step(3);
    reset = 1'b1;
    exp_at(1, "t6_reset", '0, 0, 2, 1'b1, 1'b0, 1'b0);
    step(1);
    reset = 1'b0; grb_in = fe;
    exp_at(1, "t6_after_reset", fe, 0, 2, 1'b1, 1'b0, 1'b0);
    step(3);

    @(posedge clk);
    tests++;
    if (sq.size() != 0 || rq.size() != 0) begin
      fails++;
      $display("FAIL leftover_expectations: got %0d snapshots and %0d refreshes pending, want 0 and 0",
               sq.size(), rq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
